// File: rtl/contador_descendente.sv
// Programmable down-counting timer: loads a duration, counts it to zero at a prescaled rate, pulses fin.
// Optional macro CONTADOR_AUTORECARGA_EN: reload from the last loaded value for a periodic fin.
module contador_descendente #(
  parameter int N        = 8,
  parameter int PRESCALE = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] valor_inicial,
  input  logic         start,
  input  logic         pause,
  output logic [N-1:0] cuenta,
  output logic         activo,
  output logic         fin
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          tick;

`ifdef CONTADOR_AUTORECARGA_EN
  logic [N-1:0] recarga;
`endif

  assign tick = (prescaler == PRE_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cuenta    <= '0;
      prescaler <= '0;
      activo    <= 1'b0;
      fin       <= 1'b0;
`ifdef CONTADOR_AUTORECARGA_EN
      recarga   <= '0;
`endif
    end else begin
      fin <= 1'b0;
      if (load) begin
        // A load always wins and aborts any count in progress.
        cuenta    <= valor_inicial;
        prescaler <= '0;
        state     <= IDLE;
        activo    <= 1'b0;
`ifdef CONTADOR_AUTORECARGA_EN
        recarga   <= valor_inicial;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (cuenta != '0) begin
                state  <= RUN;
                activo <= 1'b1;
              end else begin
                state <= DONE;
                fin   <= 1'b1;
              end
            end
          end
          RUN: begin
            if (!start && pause) begin
              state  <= PAUSE;
              activo <= 1'b0;
            end else if (tick) begin
              prescaler <= '0;
              if (cuenta == N'(1)) begin
                fin <= 1'b1;
`ifdef CONTADOR_AUTORECARGA_EN
                if (recarga != '0) begin
                  cuenta <= recarga;
                end else begin
                  cuenta <= '0;
                  state  <= DONE;
                  activo <= 1'b0;
                end
`else
                cuenta <= '0;
                state  <= DONE;
                activo <= 1'b0;
`endif
              end else begin
                cuenta <= cuenta - N'(1);
              end
            end else begin
              prescaler <= prescaler + PW'(1);
            end
          end
          PAUSE: begin
            // Prescaler is left untouched so the resumed period loses no ticks.
            if (start) begin
              state  <= RUN;
              activo <= 1'b1;
            end
          end
          DONE: begin
            cuenta <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_descendente.sv
// Scoreboard bench for contador_descendente: two instances (PRESCALE=4 and PRESCALE=1) share stimulus
// and are compared every cycle against an elapsed-time reference model.
module tb_contador_descendente;

  localparam int N = 4;

`ifdef CONTADOR_AUTORECARGA_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [N-1:0] valor_inicial = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;

  logic [N-1:0] cuenta4, cuenta1;
  logic         activo4, activo1, fin4, fin1;

  contador_descendente #(.N(N), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .valor_inicial(valor_inicial),
    .start(start), .pause(pause), .cuenta(cuenta4), .activo(activo4), .fin(fin4)
  );

  contador_descendente #(.N(N), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .valor_inicial(valor_inicial),
    .start(start), .pause(pause), .cuenta(cuenta1), .activo(activo1), .fin(fin1)
  );

  always #5 clk = ~clk;

  // Reference model: remaining count derived from running cycles elapsed in the current period.
  typedef struct {
    int mode;
    int v;
    int el;
    bit fin;
  } mdl_t;

  typedef struct {
    int c4, a4, f4, c1, a1, f1;
  } exp_t;

  mdl_t m[2];
  int   pre[2] = '{4, 1};
  exp_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int m_cuenta(input int i);
    return m[i].v - m[i].el / pre[i];
  endfunction

  task automatic model_reset(input int i);
    m[i].mode = M_IDLE;
    m[i].v    = 0;
    m[i].el   = 0;
    m[i].fin  = 1'b0;
  endtask

  task automatic model_step(input int i, input bit ld, input int val, input bit st, input bit pa);
    m[i].fin = 1'b0;
    if (ld) begin
      m[i].mode = M_IDLE;
      m[i].v    = val;
      m[i].el   = 0;
    end else begin
      case (m[i].mode)
        M_IDLE: if (st) begin
          if (m[i].v == 0) begin
            m[i].mode = M_DONE;
            m[i].fin  = 1'b1;
          end else begin
            m[i].mode = M_RUN;
          end
        end
        M_RUN: if (!st && pa) begin
          m[i].mode = M_PAUSE;
        end else begin
          m[i].el++;
          if (m[i].el == m[i].v * pre[i]) begin
            m[i].fin = 1'b1;
            m[i].el  = 0;
            if (!(AUTO && m[i].v != 0)) begin
              m[i].mode = M_DONE;
              m[i].v    = 0;
            end
          end
        end
        M_PAUSE: if (st) m[i].mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  // One clock of stimulus, applied at the falling edge; rv=0 asserts the asynchronous reset.
  task automatic cycle(input bit ld, input int val, input bit st, input bit pa, input bit rv);
    exp_t e;
    @(negedge clk);
    load          = ld;
    valor_inicial = N'(val);
    start         = st;
    pause         = pa;
    if (!rv) begin
      reset = 1'b0;
      #1;
      check("rst_async_cuenta4", int'(cuenta4), 0);
      check("rst_async_activo4", int'(activo4), 0);
      check("rst_async_fin4",    int'(fin4),    0);
      check("rst_async_cuenta1", int'(cuenta1), 0);
      check("rst_async_activo1", int'(activo1), 0);
      check("rst_async_fin1",    int'(fin1),    0);
      model_reset(0);
      model_reset(1);
    end else begin
      reset = 1'b1;
      model_step(0, ld, val, st, pa);
      model_step(1, ld, val, st, pa);
    end
    e.c4 = m_cuenta(0); e.a4 = (m[0].mode == M_RUN); e.f4 = m[0].fin;
    e.c1 = m_cuenta(1); e.a1 = (m[1].mode == M_RUN); e.f1 = m[1].fin;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: one expected entry per rising edge, sampled 2 time units after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cuenta_p4", int'(cuenta4), e.c4);
        check("activo_p4", int'(activo4), e.a4);
        check("fin_p4",    int'(fin4),    e.f4);
        check("cuenta_p1", int'(cuenta1), e.c1);
        check("activo_p1", int'(activo1), e.a1);
        check("fin_p1",    int'(fin1),    e.f1);
      end
    end
  end

  initial begin
    int r, val;
    bit ld, st, pa, rv;
    model_reset(0);
    model_reset(1);

    // Power-on reset
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // One-shot: load 3, start, run to completion
    cycle(1'b1, 3, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(16);

    // Pause/resume: pause held for 10 cycles, then resume
    cycle(1'b1, 2, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(2);
    for (int k = 0; k < 10; k++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(10);

    // Boundary: load 0 then start, then load 7 + start while in DONE
    cycle(1'b1, 0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(3);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 7, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Abort: reload during RUN
    cycle(1'b1, 5, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(3);
    cycle(1'b1, 9, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Asynchronous reset in the middle of a run with cuenta=5
    cycle(1'b1, 5, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    idle(2);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic with start and pause never asserted together
    for (int k = 0; k < 1500; k++) begin
      r   = $urandom_range(0, 199);
      ld  = (r < 12);
      st  = (r >= 12 && r < 60);
      pa  = (r >= 60 && r < 84);
      rv  = (r != 199);
      val = $urandom_range(0, 6);
      cycle(ld, val, st, pa, rv);
    end
    idle(2);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #3;
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/contador_descendente.md
Name: contador_descendente

Overview:
- Programmable down-counting timer for the fire-fighting machine controller: the decrementing counterpart of the free-running up counter.
- Loads a duration, counts it down to zero at a prescaled rate, and issues a one-cycle completion pulse.
- Used by the control FSM to time pump/valve activation windows.
- Sits between the control FSM (load/start/pause) and the actuator and display logic (cuenta/activo/fin).

Parameters:
- N, 8, width of the count value.
- PRESCALE, 50000, clk cycles per decrement; must be >= 1. PRESCALE=1 decrements every cycle.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- load  input  1  synchronous load strobe for valor_inicial.
- valor_inicial  input  N  value captured on load.
- start  input  1  begin or resume counting.
- pause  input  1  freeze counting while running.
- cuenta  output  N  current remaining count.
- activo  output  1  high while state is RUN.
- fin  output  1  one-cycle pulse on reaching zero.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cuenta=0, prescaler=0, activo=0, fin=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered. activo = (state==RUN).
- Input priority in the same cycle: load > start > pause.
- load (any state): cuenta<=valor_inicial, prescaler<=0, state<=IDLE, fin<=0. A load during RUN or PAUSE aborts the count.
- IDLE:
  - start with cuenta!=0 -> RUN.
  - start with cuenta==0 -> DONE, fin=1 the next cycle.
  - pause is ignored.
- RUN:
  - prescaler increments every cycle.
  - When prescaler==PRESCALE-1: prescaler<=0 and cuenta<=cuenta-1.
  - If that decrement takes cuenta from 1 to 0: state<=DONE, fin<=1 in the same edge.
  - pause (without load) -> PAUSE; prescaler and cuenta hold.
  - start while in RUN: no effect.
- PAUSE: everything holds. start -> RUN, and the prescaler resumes from its held value (no tick lost or gained).
- DONE: cuenta=0, activo=0. fin is high only in the first cycle of DONE. start is ignored; leave DONE only via load or reset.
- No wrap-around: cuenta never decrements below 0.
- Latency: from start accepted to first decrement = PRESCALE cycles. Total RUN time for value V = V*PRESCALE cycles.
- Prescaler width = clog2(PRESCALE), minimum 1 bit.
- Reset asserted mid-count returns to IDLE/0 immediately. No fin pulse is generated.

Optional Feature:
- Macro CONTADOR_AUTORECARGA_EN.
- Defined:
  - A shadow register recarga captures valor_inicial on every load.
  - On reaching zero in RUN, fin pulses as normal, but the state stays RUN, cuenta<=recarga and prescaler<=0 on that same edge, producing a periodic fin every recarga*PRESCALE cycles.
  - If recarga==0, behave as the undefined build (go to DONE).
  - pause and load behave as specified.
- Undefined: no shadow register; behaviour exactly as above (one-shot).

Test Plan (N=4, PRESCALE=4 unless noted):
- Reset: reset=0 mid-RUN with cuenta=5 -> cuenta=0, activo=0, fin=0 asynchronously. After release, state=IDLE.
- One-shot: load 3, start -> activo=1; cuenta 3->2->1->0 at 4-cycle intervals; fin=1 for exactly one cycle, 12 cycles after start accepted; activo=0 afterwards.
- Pause/resume: load 2, start, pause after 2 cycles for 10 cycles, start -> cuenta held at 2 during the pause; zero reached 8 running cycles total after the initial start (pause time excluded).
- Boundary: load 0, start -> DONE next edge, single fin pulse. Simultaneous load 7 + start in DONE -> load wins, state=IDLE, cuenta=7.
- Abort: load 5, start, then load 9 during RUN -> IDLE, cuenta=9, no fin. PRESCALE=1 variant: load 2, start -> fin exactly 2 cycles after start.
- CONTADOR_AUTORECARGA_EN: load 2, start -> fin pulses every 8 cycles, activo stays 1, cuenta sequence 2,1,2,1,...; pause stops the pulses.
